// File: rtl/tag_rx_phase_sched.sv
`timescale 1ns/1ps
// tag_rx_phase_sched: stepped-chirp phase stream generator for the tag_rx mixer.
// Frames are made of symbols, and symbols are made of samples. Within a symbol
// the phase advances by inc_s on every sample. At each symbol boundary the start
// phase moves down by nph_shift and the increment grows by dph_inc. Output is
// AXI-Stream. tlast marks the last sample of each symbol.
module tag_rx_phase_sched #(
  parameter int PHASE_WIDTH = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int GAP_WIDTH   = 16,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   srst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_continuous,
  input  logic [PHASE_WIDTH-1:0] cfg_nsig,
  input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
  input  logic [PHASE_WIDTH-1:0] cfg_start_ph,
  input  logic [PHASE_WIDTH-1:0] cfg_start_ph_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_dph_inc,
  input  logic [PHASE_WIDTH-1:0] cfg_nph_shift,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  output logic [PHASE_WIDTH-1:0] phase_tdata,
  output logic                   phase_tvalid,
  output logic                   phase_tlast,
  input  logic                   phase_tready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   cfg_err,
  output logic [NSYMB_WIDTH-1:0] symb_idx,
  output logic [PHASE_WIDTH-1:0] samp_idx,
  output logic [FCNT_WIDTH-1:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t state_q, state_d;

  // Shadow copies of the configuration, captured when a frame is armed.
  logic [PHASE_WIDTH-1:0] nsig_q, dph_q, nph_q;
  logic [NSYMB_WIDTH-1:0] nsymb_q;
  logic [GAP_WIDTH-1:0]   gap_q, gap_cnt_q;

  // Incremental phase-law state.
  logic [PHASE_WIDTH-1:0] phase_q, inc_q, sp_q, samp_q;
  logic [NSYMB_WIDTH-1:0] symb_q;
  logic [FCNT_WIDTH-1:0]  fcnt_q;
  logic                   done_q, err_q, abort_pend_q;

  // Decoded control for this cycle.
  logic beat, last_samp, last_symb, cfg_ok, abort_now;
  logic load, samp_adv, symb_adv, done_d, err_d, pend_d;

  assign beat      = (state_q == RUN) && phase_tready;
  assign last_samp = (samp_q == nsig_q - PHASE_WIDTH'(1));
  assign last_symb = (symb_q == nsymb_q - NSYMB_WIDTH'(1));
  assign cfg_ok    = (cfg_nsig != '0) && (cfg_nsymb != '0);
  assign abort_now = abort || abort_pend_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every clocked assignment is non-blocking, so all registers update together from values sampled at the same edge.
    if (!reset_n) begin
      state_q <= IDLE;
    end else if (srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    // NOTE: defaults come first, so no path leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    load     = 1'b0;
    samp_adv = 1'b0;
    symb_adv = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pend_d   = abort_pend_q;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (beat) begin
          if (abort_now) begin
            // An abort beats a simultaneous tlast or re-arm. No frame is counted.
            state_d = IDLE;
            pend_d  = 1'b0;
          end else if (!last_samp) begin
            samp_adv = 1'b1;
          end else if (!last_symb) begin
            symb_adv = 1'b1;
            if (gap_q != '0) state_d = GAP;
          end else begin
            done_d = 1'b1;
            if (cfg_continuous && cfg_ok) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              err_d   = cfg_continuous;
            end
          end
        end else if (abort) begin
          // The stalled beat must still complete. Remember the abort until the handshake.
          pend_d = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shadow config, phase accumulator, indices, gap timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nsig_q <= '0; nsymb_q <= '0; dph_q <= '0; nph_q <= '0; gap_q <= '0;
      phase_q <= '0; inc_q <= '0; sp_q <= '0; samp_q <= '0; symb_q <= '0;
      gap_cnt_q <= '0;
    end else if (srst) begin
      nsig_q <= '0; nsymb_q <= '0; dph_q <= '0; nph_q <= '0; gap_q <= '0;
      phase_q <= '0; inc_q <= '0; sp_q <= '0; samp_q <= '0; symb_q <= '0;
      gap_cnt_q <= '0;
    end else if (load) begin
      nsig_q  <= cfg_nsig;
      nsymb_q <= cfg_nsymb;
      dph_q   <= cfg_dph_inc;
      nph_q   <= cfg_nph_shift;
      gap_q   <= cfg_gap;
      phase_q <= cfg_start_ph;
      sp_q    <= cfg_start_ph;
      inc_q   <= cfg_start_ph_inc;
      samp_q  <= '0;
      symb_q  <= '0;
    end else if (samp_adv) begin
      phase_q <= phase_q + inc_q;
      samp_q  <= samp_q + PHASE_WIDTH'(1);
    end else if (symb_adv) begin
      // The next symbol starts at sp - nph_shift, and its step grows by dph_inc.
      phase_q   <= sp_q - nph_q;
      sp_q      <= sp_q - nph_q;
      inc_q     <= inc_q + dph_q;
      samp_q    <= '0;
      symb_q    <= symb_q + NSYMB_WIDTH'(1);
      gap_cnt_q <= gap_q;
    end else if (state_q == GAP) begin
      gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
    end
  end

  // Status: pending abort, completion/error pulses, frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fcnt_q       <= '0;
    end else if (srst) begin
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      abort_pend_q <= pend_d;
      done_q       <= done_d;
      err_q        <= err_d;
      if (done_d) fcnt_q <= fcnt_q + FCNT_WIDTH'(1);
    end
  end

  assign phase_tdata  = phase_q;
  assign phase_tvalid = (state_q == RUN);
  assign phase_tlast  = phase_tvalid && last_samp;
  assign busy         = (state_q != IDLE);
  assign frame_done   = done_q;
  assign cfg_err      = err_q;
  assign symb_idx     = symb_q;
  assign samp_idx     = samp_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_tag_rx_phase_sched.sv
`timescale 1ns/1ps
// Self-checking bench for tag_rx_phase_sched. Expected phases come from the
// closed-form law phase(s,k) = start_ph - s*nph_shift + k*(start_ph_inc + s*dph_inc).
module tb_tag_rx_phase_sched;
  localparam int PW = 24;
  localparam int NW = 16;
  localparam int GW = 16;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          srst = 1'b0, start = 1'b0, abort = 1'b0, cfg_continuous = 1'b0;
  logic [PW-1:0] cfg_nsig = '0, cfg_start_ph = '0, cfg_start_ph_inc = '0;
  logic [PW-1:0] cfg_dph_inc = '0, cfg_nph_shift = '0;
  logic [NW-1:0] cfg_nsymb = '0;
  logic [GW-1:0] cfg_gap = '0;
  logic          phase_tready = 1'b0;
  logic [PW-1:0] phase_tdata, samp_idx;
  logic          phase_tvalid, phase_tlast, busy, frame_done, cfg_err;
  logic [NW-1:0] symb_idx;
  logic [FW-1:0] frame_count;

  tag_rx_phase_sched #(.PHASE_WIDTH(PW), .NSYMB_WIDTH(NW), .GAP_WIDTH(GW), .FCNT_WIDTH(FW)) dut (
    .clk(clk), .reset_n(reset_n), .srst(srst), .start(start), .abort(abort),
    .cfg_continuous(cfg_continuous), .cfg_nsig(cfg_nsig), .cfg_nsymb(cfg_nsymb),
    .cfg_start_ph(cfg_start_ph), .cfg_start_ph_inc(cfg_start_ph_inc),
    .cfg_dph_inc(cfg_dph_inc), .cfg_nph_shift(cfg_nph_shift), .cfg_gap(cfg_gap),
    .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid), .phase_tlast(phase_tlast),
    .phase_tready(phase_tready), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .symb_idx(symb_idx), .samp_idx(samp_idx), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_fcount = 0;

  // Snapshot of the configuration a frame was started with.
  logic [PW-1:0] m_nsig, m_start_ph, m_inc0, m_dph, m_nph;
  logic [NW-1:0] m_nsymb;
  logic [GW-1:0] m_gap;

  function automatic logic [PW-1:0] model_phase(input int s, input int k);
    logic [63:0] v;
    v = 64'(m_start_ph) - 64'(s) * 64'(m_nph)
      + 64'(k) * (64'(m_inc0) + 64'(s) * 64'(m_dph));
    return v[PW-1:0];
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 1;
      2:       return 1'($urandom_range(0, 1));
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic set_cfg(input int nsig, input int nsymb, input logic [PW-1:0] sp,
                         input logic [PW-1:0] inc, input logic [PW-1:0] dph,
                         input logic [PW-1:0] nph, input int gap);
    cfg_nsig = PW'(nsig); cfg_nsymb = NW'(nsymb); cfg_start_ph = sp;
    cfg_start_ph_inc = inc; cfg_dph_inc = dph; cfg_nph_shift = nph; cfg_gap = GW'(gap);
  endtask

  // Start nframes frames (continuous when more than one) and check every beat,
  // every stall, every gap length and every frame_done pulse against the model.
  task automatic run_frames(input string name, input int nframes, input int mode, input bit scramble);
    int f = 0, s = 0, k = 0, low = 0, cyc = 0, exp_low;
    bit done_exp = 1'b0, stall = 1'b0;
    logic [64:0] held, exp_v, got_v;
    m_nsig = cfg_nsig; m_nsymb = cfg_nsymb; m_start_ph = cfg_start_ph;
    m_inc0 = cfg_start_ph_inc; m_dph = cfg_dph_inc; m_nph = cfg_nph_shift; m_gap = cfg_gap;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    cfg_continuous = (nframes > 1);
    phase_tready = pick_ready(mode, 0);
    while (f < nframes && cyc < 20000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (scramble) begin
        cfg_nsig = PW'($urandom); cfg_nsymb = NW'($urandom); cfg_start_ph = PW'($urandom);
        cfg_start_ph_inc = PW'($urandom); cfg_dph_inc = PW'($urandom);
        cfg_nph_shift = PW'($urandom); cfg_gap = GW'($urandom);
      end
      got_v = {phase_tdata, phase_tlast, symb_idx, samp_idx};
      tests++;
      if (frame_done !== done_exp) begin
        fails++;
        $display("FAIL %s frame_done: got %b expected %b (cycle %0d)", name, frame_done, done_exp, cyc);
      end
      done_exp = 1'b0;
      if (cyc == 1) begin
        tests++;
        if (phase_tvalid !== 1'b1) begin
          fails++;
          $display("FAIL %s start latency: tvalid got %b expected 1", name, phase_tvalid);
        end
      end
      if (stall) begin
        tests++;
        if (got_v !== held) begin
          fails++;
          $display("FAIL %s stall hold: got %h expected %h", name, got_v, held);
        end
      end
      if (!phase_tvalid) low++;
      phase_tready = pick_ready(mode, cyc);
      if (phase_tvalid && phase_tready) begin
        exp_v = {model_phase(s, k), k == int'(m_nsig) - 1, NW'(s), PW'(k)};
        tests++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL %s beat f%0d s%0d k%0d: got %h expected %h", name, f, s, k, got_v, exp_v);
        end
        if (k == 0 && cyc > 1) begin
          exp_low = (s == 0) ? 0 : int'(m_gap);
          tests++;
          if (low != exp_low) begin
            fails++;
            $display("FAIL %s gap before s%0d: got %0d idle cycles expected %0d", name, s, low, exp_low);
          end
        end
        low = 0;
        if (f == nframes - 1 && f > 0 && s == 0 && k == 0) cfg_continuous = 1'b0;
        k++;
        if (k == int'(m_nsig)) begin
          k = 0; s++;
          if (s == int'(m_nsymb)) begin
            s = 0; f++; done_exp = 1'b1; exp_fcount++;
          end
        end
      end
      stall = phase_tvalid && !phase_tready;
      held  = got_v;
    end
    if (cyc >= 20000) begin
      fails++;
      $display("FAIL %s timeout: got %0d frames expected %0d", name, f, nframes);
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || frame_count !== FW'(exp_fcount)) begin
      fails++;
      $display("FAIL %s end: got done=%b busy=%b count=%0d expected done=1 busy=0 count=%0d",
               name, frame_done, busy, frame_count, exp_fcount);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({phase_tdata, phase_tvalid, phase_tlast, busy, frame_done, cfg_err, symb_idx, samp_idx, frame_count} !== '0) begin
      fails++;
      $display("FAIL reset state: got tdata=%h tvalid=%b busy=%b count=%0d expected all zero",
               phase_tdata, phase_tvalid, busy, frame_count);
    end
  endtask

  task automatic test_basic();
    set_cfg(4, 3, 24'h0, 24'h100, 24'h100, 24'h0, 0);
    run_frames("basic", 1, 0, 1'b0);
  endtask

  task automatic test_stall();
    set_cfg(4, 3, 24'h0, 24'h100, 24'h100, 24'h0, 0);
    run_frames("stall_1010", 1, 1, 1'b0);
  endtask

  task automatic test_gap();
    set_cfg(4, 3, 24'h0, 24'h100, 24'h100, 24'h10, 3);
    run_frames("gap3", 1, 0, 1'b0);
    set_cfg(1, 3, 24'h123456, 24'h7, 24'h1, 24'h5, 2);
    run_frames("nsig1_gap2", 1, 2, 1'b0);
  endtask

  task automatic test_continuous();
    set_cfg(2, 2, 24'h10, 24'h20, 24'h3, 24'h1, 0);
    run_frames("continuous", 3, 0, 1'b0);
  endtask

  task automatic test_abort();
    int fc0;
    // Abort while the current beat is stalled: beat held, then IDLE on handshake.
    set_cfg(4, 3, 24'h0, 24'h100, 24'h100, 24'h0, 0);
    m_start_ph = 24'h0; m_inc0 = 24'h100; m_dph = 24'h100; m_nph = 24'h0;
    fc0 = exp_fcount;
    @(negedge clk); start = 1'b1; phase_tready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); phase_tready = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) begin
      tests++;
      if (phase_tvalid !== 1'b1 || busy !== 1'b1 || phase_tdata !== model_phase(0, 1) || samp_idx !== PW'(1)) begin
        fails++;
        $display("FAIL abort hold: got tvalid=%b busy=%b tdata=%h expected tvalid=1 busy=1 tdata=%h",
                 phase_tvalid, busy, phase_tdata, model_phase(0, 1));
      end
      @(negedge clk);
    end
    phase_tready = 1'b1;
    @(negedge clk);
    tests++;
    if (phase_tvalid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL abort idle: got tvalid=%b busy=%b done=%b expected 0 0 0", phase_tvalid, busy, frame_done);
    end
    // Abort on the final tlast beat wins over completion.
    set_cfg(2, 1, 24'h0, 24'h1, 24'h0, 24'h0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (2) begin
      tests++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== FW'(fc0)) begin
        fails++;
        $display("FAIL abort last beat: got busy=%b done=%b count=%0d expected 0 0 %0d",
                 busy, frame_done, frame_count, fc0);
      end
      @(negedge clk);
    end
    // Abort during a gap.
    set_cfg(1, 2, 24'h0, 24'h1, 24'h0, 24'h0, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || phase_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL abort in gap: got busy=%b tvalid=%b expected 0 0", busy, phase_tvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < 2; i++) begin
      set_cfg((i == 0) ? 0 : 3, (i == 0) ? 3 : 0, 24'h0, 24'h1, 24'h0, 24'h0, 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      tests++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err zero cfg %0d: got err=%b busy=%b expected 1 0", i, cfg_err, busy);
      end
      @(negedge clk);
      tests++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL cfg_err pulse width %0d: got err=%b busy=%b expected 0 0", i, cfg_err, busy);
      end
    end
    // Zero config seen at a continuous re-arm: frame completes, then error and IDLE.
    set_cfg(1, 1, 24'h0, 24'h1, 24'h0, 24'h0, 0);
    cfg_continuous = 1'b1; phase_tready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cfg_nsig = '0;
    @(negedge clk);
    exp_fcount++;
    tests++;
    if (frame_done !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b0 || frame_count !== FW'(exp_fcount)) begin
      fails++;
      $display("FAIL rearm cfg_err: got done=%b err=%b busy=%b count=%0d expected 1 1 0 %0d",
               frame_done, cfg_err, busy, frame_count, exp_fcount);
    end
    cfg_continuous = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_srst();
    set_cfg(4, 3, 24'h55, 24'h100, 24'h100, 24'h0, 0);
    @(negedge clk); start = 1'b1; phase_tready = 1'b1;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    exp_fcount = 0;
    tests++;
    if ({phase_tdata, phase_tvalid, busy, symb_idx, samp_idx, frame_count} !== '0) begin
      fails++;
      $display("FAIL srst clear: got tdata=%h tvalid=%b busy=%b count=%0d expected all zero",
               phase_tdata, phase_tvalid, busy, frame_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      set_cfg($urandom_range(1, 5), $urandom_range(1, 4), PW'($urandom), PW'($urandom),
              PW'($urandom), PW'($urandom), $urandom_range(0, 3));
      run_frames("random", 1, 2 + (i % 2), 1'b1);
    end
    set_cfg($urandom_range(1, 3), $urandom_range(1, 3), PW'($urandom), PW'($urandom),
            PW'($urandom), PW'($urandom), $urandom_range(0, 2));
    run_frames("random_cont", 3, 3, 1'b0);
  endtask

  task automatic test_async_reset();
    set_cfg(4, 3, 24'h0, 24'h100, 24'h100, 24'h0, 0);
    @(negedge clk); start = 1'b1; phase_tready = 1'b1;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (phase_tvalid !== 1'b0 || busy !== 1'b0 || phase_tdata !== '0 || frame_count !== '0) begin
      fails++;
      $display("FAIL async reset: got tvalid=%b busy=%b tdata=%h count=%0d expected 0 0 0 0",
               phase_tvalid, busy, phase_tdata, frame_count);
    end
    exp_fcount = 0;
    @(negedge clk); reset_n = 1'b1;
    run_frames("after_reset", 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_continuous();
    test_abort();
    test_cfg_err();
    test_srst();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tag_rx_phase_sched.md
Name: tag_rx_phase_sched

Overview:
- Frame scheduler that generates the per-sample phase stream consumed by the tag receiver's frequency-shift mixer.
- Produces a stepped-chirp phase sequence organised as frames of symbols of samples, with AXI-Stream handshaking on the phase interface.
- Provides per-symbol tlast, optional inter-symbol gaps and continuous re-triggering, and frame status for software and the capture logic.
- Sits between the control registers and the tag_rx phase input (phase_tdata/tvalid/tlast/tready).

Parameters:
PHASE_WIDTH, 24, width of phase accumulator, increments and sample counter
NSYMB_WIDTH, 16, width of symbol counter and cfg_nsymb
GAP_WIDTH, 16, width of inter-symbol gap counter
FCNT_WIDTH, 16, width of completed-frame counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
srst  in  1  synchronous clear; same effect as reset, applied on a clk edge
start  in  1  pulse; arms a frame from IDLE
abort  in  1  pulse; terminates the frame (see Behaviour)
cfg_continuous  in  1  1 = re-arm automatically after each frame
cfg_nsig  in  PHASE_WIDTH  samples per symbol
cfg_nsymb  in  NSYMB_WIDTH  symbols per frame
cfg_start_ph  in  PHASE_WIDTH  phase of sample 0 of symbol 0
cfg_start_ph_inc  in  PHASE_WIDTH  phase increment in symbol 0
cfg_dph_inc  in  PHASE_WIDTH  increment step added per symbol
cfg_nph_shift  in  PHASE_WIDTH  start phase decrement per symbol
cfg_gap  in  GAP_WIDTH  idle cycles between symbols
phase_tdata  out  PHASE_WIDTH  phase sample
phase_tvalid  out  1  phase sample valid
phase_tlast  out  1  last sample of a symbol
phase_tready  in  1  downstream ready
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the last beat of a frame
cfg_err  out  1  one-cycle pulse when start is rejected
symb_idx  out  NSYMB_WIDTH  current symbol (0-based)
samp_idx  out  PHASE_WIDTH  current sample within symbol (0-based)
frame_count  out  FCNT_WIDTH  completed frames; wraps

Behaviour:
- Reset (async assert, sync release) and srst drive state IDLE and clear every output to 0, including phase_tdata and frame_count.
- cfg_* is sampled into shadow registers only on accepted start and on an automatic continuous re-arm. Changes to cfg_* mid-frame have no effect.
- States:
  - IDLE: start with cfg_nsig!=0 and cfg_nsymb!=0 -> RUN next cycle. start with either value 0 -> cfg_err pulse, remain IDLE.
  - RUN: phase_tvalid=1. A beat completes on phase_tvalid&&phase_tready. Stalls hold tdata, tlast and all indices stable.
  - GAP: phase_tvalid=0 for exactly gap cycles, independent of tready, then -> RUN.
- Phase law, all mod 2^PHASE_WIDTH:
  - phase(s,k) = sp_s + k*inc_s
  - sp_s = start_ph - s*nph_shift
  - inc_s = start_ph_inc + s*dph_inc
  - Implemented incrementally with registers: phase += inc per beat; at symbol end phase <- sp_s+1, inc += dph_inc, sp -= nph_shift. No multipliers.
- First beat of a frame is valid 1 cycle after start (start-to-tvalid latency 1).
- phase_tlast=1 when samp_idx==nsig-1.
- On a tlast beat:
  - Not last symbol: symb_idx+1, samp_idx=0. Enter GAP if gap!=0, else stay in RUN (back-to-back).
  - Last symbol: frame_count+1, frame_done pulses the next cycle. If continuous, re-latch cfg and RUN resumes with no idle cycle; otherwise -> IDLE.
  - A zero cfg at continuous re-arm -> cfg_err pulse, IDLE.
- abort:
  - In IDLE: ignored.
  - In GAP, or RUN with phase_tvalid and no pending beat: -> IDLE next cycle.
  - In RUN with tvalid high and tready low: the current beat is held (AXI rule: tvalid never drops before handshake); IDLE follows on that handshake.
  - No frame_done after abort; frame_count unchanged.
- abort has priority over a simultaneous tlast/continuous re-arm. start while busy is ignored.
- nsig=1: every beat carries tlast. nsymb=1: frame is a single symbol.

Test Plan:
- nsig=4, nsymb=3, start_ph=0, start_ph_inc=0x100, dph_inc=0x100, nph_shift=0, gap=0, tready=1 -> 12 beats: 0,100,200,300 / 0,200,400,600 / 0,300,600,900 (hex); tlast on beats 4, 8, 12; frame_done 1 cycle after beat 12; frame_count=1.
- Same config, tready toggling 1010… -> identical data sequence; tdata and tlast stable during stalls.
- gap=3, nph_shift=0x10 -> exactly 3 tvalid-low cycles between symbols; symbol 1 starts at 0xFFFFF0, symbol 2 at 0xFFFFE0.
- cfg_continuous=1, nsig=2, nsymb=2 -> frames back-to-back with no bubble; frame_count increments every 4 beats; clearing cfg_continuous stops after the current frame.
- abort while tready=0 mid-symbol -> beat held until tready=1, then IDLE; no frame_done. Separately, start with cfg_nsig=0 -> cfg_err pulse, busy stays 0.
- reset_n asserted mid-frame, asynchronously -> tvalid and busy go 0 immediately without a clock edge; after release, start replays the frame from phase(0,0).
